// File: rtl/cordic_sincos_sched_pkg.sv
// Shared constants and types for the CORDIC sin/cos pipeline and its scheduler.
package pkg_cordic_sincos;

    // Pipeline depth: iteration stages plus the quadrant pre-fold and the
    // post-process (sign fix + output register).
    localparam int STAGES         = 16;
    localparam int PRE_DEPTH      = 1;
    localparam int POST_DEPTH     = 2;
    localparam int CORDIC_LATENCY = STAGES + PRE_DEPTH + POST_DEPTH;

    // Tag ID is sized for the largest supported requester count (8).
    localparam int IDW = 3;

    typedef struct packed {
        logic           v;
        logic [IDW-1:0] id;
    } cordic_tag_t;

endpackage

// File: rtl/cordic_sincos_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id
);

    logic [IW-1:0] last;
    logic          found;

    // Pick the first requester after last; grant only when the pipe advances.
    always_comb begin
        int j;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(last) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt_id = IW'(j);
            end
        end
        if (adv && found) gnt[gnt_id] = 1'b1;
    end

    // Pointer moves to the winner only on an actual issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          last <= IW'(N - 1);
        else if (adv && found) last <= gnt_id;
    end

endmodule

// File: rtl/cordic_sincos_sched.sv
// Shares one cordic_sincos pipeline among NREQ requesters. IDs ride a tag
// line matched to the pipeline depth; the result register backpressures the
// whole pipeline through o_cordic_en.
module cordic_sincos_sched
    import pkg_cordic_sincos::*;
#(
    parameter int NREQ    = 4,
    parameter int BITS    = 16,
    parameter int LATENCY = CORDIC_LATENCY
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*BITS-1:0]     i_req_theta,
    output logic [NREQ-1:0]          o_req_ready,
    output logic                     o_cordic_en,
    output logic                     o_cordic_start,
    output logic [BITS-1:0]          o_cordic_theta,
    input  logic                     i_cordic_valid,
    input  logic [BITS-1:0]          i_cordic_sin,
    input  logic [BITS-1:0]          i_cordic_cos,
    output logic                     o_res_valid,
    output logic [$clog2(NREQ)-1:0]  o_res_id,
    output logic [BITS-1:0]          o_res_sin,
    output logic [BITS-1:0]          o_res_cos,
    input  logic                     i_res_ready,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY + 2);

    logic [IW-1:0] gnt_id;
    cordic_tag_t   tag_in;
    cordic_tag_t   tag_q [LATENCY];
    logic [CW-1:0] cnt;
    logic          issue;
    logic          retire;
    logic          unused_tag_bits;

    // Pipeline advances unless a held result is waiting on the consumer.
    assign o_cordic_en    = !o_res_valid || i_res_ready;
    assign o_cordic_start = o_cordic_en && |i_req_valid;
    assign issue          = o_cordic_start;
    assign retire         = o_res_valid && i_res_ready;
    assign o_busy         = (cnt != '0);

    rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (i_req_valid),
        .adv     (o_cordic_en),
        .gnt     (o_req_ready),
        .gnt_id  (gnt_id)
    );

    // Steer the granted angle; zero when nothing is issued.
    always_comb begin
        o_cordic_theta = '0;
        if (o_cordic_start) o_cordic_theta = i_req_theta[int'(gnt_id)*BITS +: BITS];
        tag_in    = '0;
        tag_in.v  = o_cordic_start;
        tag_in.id = IDW'(gnt_id);
    end

    // Tag delay line, frozen together with the pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
        end else if (o_cordic_en) begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Upper ID bits are spare when NREQ < 8.
    assign unused_tag_bits = ^tag_q[LATENCY-1].id;

    // Result register; holds while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_res_valid <= 1'b0;
            o_res_id    <= '0;
            o_res_sin   <= '0;
            o_res_cos   <= '0;
        end else if (o_cordic_en) begin
            o_res_valid <= i_cordic_valid;
            o_res_id    <= tag_q[LATENCY-1].id[IW-1:0];
            o_res_sin   <= i_cordic_sin;
            o_res_cos   <= i_cordic_cos;
        end
    end

    // Sticky flag: pipeline valid disagrees with the tag that should match it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                           o_err <= 1'b0;
        else if (o_cordic_en && (i_cordic_valid != tag_q[LATENCY-1].v)) o_err <= 1'b1;
    end

    // In-flight count: issued but not yet taken by the consumer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              cnt <= '0;
        else if (issue && !retire) cnt <= cnt + CW'(1);
        else if (!issue && retire) cnt <= cnt - CW'(1);
    end

endmodule

// File: doc/cordic_sincos_sched.md
# cordic_sincos_sched

Shares one `cordic_sincos` pipeline among `NREQ` requesters, such as UART command channels or test generators. Each requester has a valid/ready request port. A round-robin arbiter feeds one angle per cycle into the pipeline. The requester ID travels through a tag delay line aligned with the pipeline latency, and each sin/cos result is returned through a registered output with backpressure. The block also drives the pipeline's `i_pipeline_en`, so the whole pipeline stalls when the result consumer stalls.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `BITS`, 16: angle/result width; must match the pipeline `BITS`.
- `LATENCY`, 19: enabled clock edges from a sampled `i_start` to `o_valid` at the pipeline output; must match the pipeline build.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req_valid` in `NREQ`: request valid, one bit per requester.
- `i_req_theta` in `NREQ*BITS`: signed angle per requester; requester *k* uses bits `[k*BITS +: BITS]`.
- `o_req_ready` out `NREQ`: request accepted this cycle (one-hot or zero).
- `o_cordic_en` out 1: drives the pipeline `i_pipeline_en`.
- `o_cordic_start` out 1: drives the pipeline `i_start`.
- `o_cordic_theta` out `BITS`: drives the pipeline `i_theta`.
- `i_cordic_valid` in 1: pipeline result valid.
- `i_cordic_sin` in `BITS`: pipeline sin result.
- `i_cordic_cos` in `BITS`: pipeline cos result.
- `o_res_valid` out 1: result valid.
- `o_res_id` out `$clog2(NREQ)`: ID of the originating requester.
- `o_res_sin` out `BITS`: registered sin result.
- `o_res_cos` out `BITS`: registered cos result.
- `i_res_ready` in 1: consumer accepts the result.
- `o_busy` out 1: at least one transaction is in flight or held.
- `o_err` out 1: sticky tag/valid misalignment flag.

## Operation
- **Pipeline enable:** `o_cordic_en = !o_res_valid || i_res_ready`. The enable is combinational.
- **Arbitration:**
  - Round-robin pointer `last` (reset value `NREQ-1`). The search starts at `last+1` and wraps modulo `NREQ`.
  - The grant `g` is the first requester with `i_req_valid` set.
  - Grants happen only when `o_cordic_en` = 1.
- **Issue:**
  - `o_cordic_start = o_cordic_en && |i_req_valid`.
  - `o_cordic_theta` = theta of `g`, or 0 when there is no grant.
  - `o_req_ready[g] = o_cordic_start`.
  - `last <= g` on issue; `last` is unchanged otherwise.
- **Tag line:**
  - `LATENCY` entries of `{v, id}`, shifting on `o_cordic_en` only.
  - Entry 0 loads `{o_cordic_start, g}`.
  - Entry `LATENCY-1` is aligned with `i_cordic_valid`.
- **Result register:** on `o_cordic_en`, loads `o_res_valid <= i_cordic_valid`, plus `o_res_sin`, `o_res_cos` and `o_res_id` from the last tag entry.
- **Misalignment check:** on an enabled edge, if `i_cordic_valid` ≠ the last tag `v`, set `o_err`. It clears only on reset.
- **In-flight counter:**
  - Width `$clog2(LATENCY+2)`.
  - +1 on issue; −1 on `o_res_valid && i_res_ready`.
  - Both events in the same cycle leave it unchanged.
  - `o_busy` = counter ≠ 0.
- **No-stall case:** with `i_res_ready` held at 1, throughput is one result per cycle with no bubbles.
- **Width rules:** theta and results pass through unmodified. No arithmetic on the datapath.

## Timing
- **Reset values:** `o_res_valid`, `o_res_id`, `o_res_sin`, `o_res_cos`, `o_err`, `o_busy` = 0; tag line all `v` = 0; counter 0; `last` = `NREQ-1`.
- **Combinational outputs:** `o_req_ready`, `o_cordic_start` and `o_cordic_theta` are combinational. With `i_rst_n` low they are 0 only if `i_req_valid` = 0. The pipeline is reset by the same `i_rst_n`, so nothing is issued into a reset pipeline.
- **Latency:** a request accepted at edge E0 gives `o_res_valid` after edge E(`LATENCY`+1) when there is no stall. Each stalled cycle adds one cycle.
- **Stall:**
  - While `o_res_valid` && !`i_res_ready`: every output is held, no grant is made, and the tag line and pipeline are frozen.
  - A requester whose valid is high but is not granted must hold its valid and theta; ready is never issued without a grant.
- **Reset mid-operation:** all in-flight transactions are dropped. After release, no result is emitted until a new issue.
- **Simultaneous requests:** all `NREQ` requesting continuously are served in order `last+1`, `last+2`, ... with one grant per enabled cycle.

## Structure
- Add to `pkg_cordic_sincos`:
  - `CORDIC_LATENCY`, derived from `STAGES` plus preprocess and postprocess depth; it is the default for `LATENCY`.
  - The typedef `cordic_tag_t` = `{logic v; logic [IDW-1:0] id;}`.
- One sub-module, `rr_arbiter`: parameter `N`; inputs `req` and `adv`; output one-hot `gnt`; owns the `last` pointer.
- Top-level integration instantiates the scheduler next to the `cordic_sincos` top, with shared `i_clk` and `i_rst_n`.

## Test plan
1. **Single request:** `NREQ`=4, `BITS`=16. Requester 2 sends theta = 0 for one cycle → `o_res_valid` exactly `LATENCY`+1 cycles later, `o_res_id` = 2, `o_res_sin` within ±2 LSB of 0, `o_err` = 0.
2. **Fairness:** all four requesters hold valid with theta = k·0x1000 → grants run 0, 1, 2, 3, 0, ... and results arrive back-to-back with matching IDs.
3. **Backpressure:** drop `i_res_ready` for 7 cycles mid-stream → `o_cordic_en` = 0 for exactly those 7 cycles, no results are lost or duplicated, and order is preserved.
4. **Simultaneous issue and retire:** issue and retire in the same cycle → the counter is unchanged. After the stream drains, `o_busy` = 0 one cycle after the last acceptance.
5. **Reset during a burst:** assert `i_rst_n` low with 10 transactions in flight → all outputs return to reset values. After release, no stray `o_res_valid` appears, and the next request completes with the correct ID.
6. **Mismatch detection:** force `LATENCY` one lower than the actual pipeline depth → `o_err` rises on the first result and stays high.
